// File: rtl/gate_accum.sv
// gate_accum: collects VEC_LEN signed fixed-point terms and presents their sum
// as one result. The Q format (FRACT_WIDTH fractional bits) passes through
// unchanged.
//
// Two states:
//   StAcc - accepting terms.
//   StOut - holding a completed result until the consumer takes it.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous flush of the partial sum (no effect in StOut)
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle
//   in_data    signed term, DATA_WIDTH bits
//   out_valid  out_data holds a completed sum
//   out_ready  consumer takes out_data (ignored in StAcc)
//   out_data   signed sum of VEC_LEN terms, DATA_WIDTH bits
//   out_sat    out_data was clamped; qualified by out_valid
//
// Configuration macro:
//   GATE_ACCUM_SATURATE_EN  defined: clamp out-of-range sums and flag out_sat.
//                           undefined: out_data wraps (two's complement) and
//                           out_sat is constant 0.

module gate_accum #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FRACT_WIDTH = 8,
    parameter int unsigned VEC_LEN     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat
);

    localparam int unsigned CntWidth = $clog2(VEC_LEN);
    localparam int unsigned AccWidth = DATA_WIDTH + CntWidth;

    // Elaboration-time guard on the legal parameter range.
    if (VEC_LEN < 2 || VEC_LEN > 256 || FRACT_WIDTH >= DATA_WIDTH) begin : g_param_check
        $error("gate_accum: illegal VEC_LEN or FRACT_WIDTH");
    end

    typedef enum logic [0:0] {StAcc, StOut} state_e;

    state_e                state_q, state_d;
    logic [AccWidth-1:0]   acc_q, acc_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sat_q, sat_d;

    logic [AccWidth-1:0]   sum;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_sat;

    // Sign-extend the term; AccWidth is wide enough that VEC_LEN terms never overflow.
    assign sum = acc_q + {{CntWidth{in_data[DATA_WIDTH-1]}}, in_data};

`ifdef GATE_ACCUM_SATURATE_EN
    // The sum fits DATA_WIDTH iff every bit above the result's sign bit matches it.
    always_comb begin
        res_data = sum[DATA_WIDTH-1:0];
        res_sat  = 1'b0;
        if (sum[AccWidth-1:DATA_WIDTH-1] != {(CntWidth+1){sum[AccWidth-1]}}) begin
            res_sat  = 1'b1;
            res_data = sum[AccWidth-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_data = sum[DATA_WIDTH-1:0];
    assign res_sat  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        sat_d    = sat_q;
        in_ready = 1'b0;
        unique case (state_q)
            StAcc: begin
                in_ready = ~clear;
                if (clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    if (cnt_q == CntWidth'(VEC_LEN - 1)) begin
                        data_d  = res_data;
                        sat_d   = res_sat;
                        // Zero now so the return to StAcc needs only a state change.
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StOut;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid = (state_q == StOut);
    assign out_data  = data_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_gate_accum.sv
// Randomized and directed bench for gate_accum (DATA_WIDTH=16, VEC_LEN=4).
// The driver keeps a reference model (list of accepted terms, integer sum) and
// pushes each expected result into a queue; a separate monitor pops and
// compares whenever the DUT presents a result.

module tb_gate_accum;

    localparam int DW = 16;
    localparam int VL = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          clear     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sat;

    gate_accum #(
        .DATA_WIDTH (DW),
        .FRACT_WIDTH(8),
        .VEC_LEN    (VL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    logic [DW:0]   exp_q[$];   // {sat, data}
    logic [DW-1:0] beats[$];   // terms accepted in the current vector
    bit            m_hold;     // model: a result is waiting for the consumer
    int            n_checks;
    int            n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference: plain integer sum of the accepted terms, then clamp or wrap.
    function automatic logic [DW:0] model_result();
        int s = 0;
        foreach (beats[i]) s += int'($signed(beats[i]));
`ifdef GATE_ACCUM_SATURATE_EN
        if (s > 32767) return {1'b1, 16'h7fff};
        if (s < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, 16'(s)};
    endfunction

    // One clock of stimulus; inputs change on the falling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic clr,
                         input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        clear     = clr;
        out_ready = ordy;
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_hold && !clr));
        check("out_valid", 32'(out_valid), 32'(m_hold));
        @(posedge clk);
        if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (clr) begin
            beats.delete();
        end else if (v) begin
            beats.push_back(d);
            if (beats.size() == VL) begin
                exp_q.push_back(model_result());
                beats.delete();
                m_hold = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        clear    = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        beats.delete();
        m_hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Monitor: compares every cycle a result is presented, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got out_valid=1 data %0h, required none",
                             out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0][DW-1:0]));
                    check("out_sat", 32'(out_sat), 32'(exp_q[0][DW]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic          v, clr, ordy;
        logic [DW-1:0] d;

        // Reset state.
        @(negedge clk);
        #1;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out_data", 32'(out_data), 32'd0);
        check("init_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #3;
        rst = 1'b0;

        // Four 1.0 terms -> 4.0.
        repeat (VL) cycle(1'b1, 16'h0100, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Large positive and negative terms: clamp or wrap.
        repeat (VL) cycle(1'b1, 16'h7000, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        repeat (VL) cycle(1'b1, 16'h9000, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Mixed signs with gaps between terms.
        cycle(1'b1, 16'h0200, 1'b0, 1'b0);
        cycle(1'b0, 16'h1234, 1'b0, 1'b0);
        cycle(1'b1, 16'hff00, 1'b0, 1'b0);
        cycle(1'b1, 16'h0080, 1'b0, 1'b0);
        cycle(1'b0, 16'h4321, 1'b0, 1'b0);
        cycle(1'b1, 16'hff80, 1'b0, 1'b0);

        // Backpressure: result held, in_valid=1 for five cycles, nothing accepted.
        repeat (5) cycle(1'b1, 16'h0400, 1'b0, 1'b0);
        cycle(1'b1, 16'h0400, 1'b1, 1'b0);  // clear in StOut has no effect
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);  // back in StAcc, in_ready=1

        // Clear discards two terms and a simultaneous beat; out_ready in StAcc ignored.
        repeat (2) cycle(1'b1, 16'h0100, 1'b0, 1'b1);
        cycle(1'b1, 16'h0100, 1'b1, 1'b1);
        repeat (VL) cycle(1'b1, 16'h0080, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Reset mid-vector, then a fresh vector.
        repeat (2) cycle(1'b1, 16'h0100, 1'b0, 1'b0);
        do_reset();
        repeat (VL) cycle(1'b1, 16'h0100, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Reset while holding a result.
        repeat (VL) cycle(1'b1, 16'h0300, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        do_reset();
        repeat (VL) cycle(1'b1, 16'h0100, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 9) < 7);
            clr  = ($urandom_range(0, 19) == 0);
            ordy = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0) d = 16'($urandom_range(0, 2048)) - 16'd1024;
            else d = 16'($urandom);
            cycle(v, d, clr, ordy);
        end

        // Drain any held result.
        for (int i = 0; i < 8 && m_hold; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
